checker_turn_ctrl: RTL and testbench

Front-end sequencer for the checkers game engine. It turns raw player buttons into a board cursor and drives the engine's select_loc through a two-phase turn: pick a piece, then pick a destination. It watches the engine's turn_count to confirm each move and times out rejected moves. It sits between the board I/O (buttons, cursor display) and the game engine.

---
 rtl/checker_turn_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_checker_turn_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checker_turn_ctrl.sv
// Purpose : turn sequencer between board buttons and the checkers engine (cursor, pick/destination, move confirm).
// Latency : a button level seen before edge e1 takes effect at edge e3; move_done/move_timeout are registered pulses.
// Backpr. : none; button pulses arriving in SETTLE or WAIT_TURN are dropped, held buttons act once.
//
// Ports:
//   clk, rst (async, active-low)
//   btn_up/btn_down/btn_left/btn_right/btn_ok : raw button levels, asynchronous to clk
//   turn_count[7:0]  : engine move counter, watched to confirm a move
//   cursor_loc[5:0]  : cursor {x[2:0], y[2:0]}
//   select_loc[5:0]  : square presented to the engine, changes only on a confirm
//   phase            : 0 picking a piece, 1 picking a destination
//   busy             : high in SETTLE and WAIT_TURN
//   move_done        : one-cycle pulse when turn_count moves during WAIT_TURN
//   move_timeout     : one-cycle pulse when WAIT_TURN expires without a count change
//   red_turn         : red to move (even turn_count)
//
// Build option: define CHECKER_CURSOR_WRAP_EN to make cursor moves wrap modulo 8
// per axis; without it moves saturate at the board edges.

`timescale 1ns/1ps

module checker_turn_ctrl #(
  parameter int PICK_SETTLE  = 2,
  parameter int TURN_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_ok,
  input  logic [7:0] turn_count,
  output logic [5:0] cursor_loc,
  output logic [5:0] select_loc,
  output logic       phase,
  output logic       busy,
  output logic       move_done,
  output logic       move_timeout,
  output logic       red_turn
);

  typedef enum logic [1:0] {
    ST_PICK   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DEST   = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_OK    = 4;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(PICK_SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TURN_TIMEOUT - 1);

  // ------------------------------------------------------------------
  // Button conditioning: 2-flop synchronizer + rising-edge detect.
  // prev is held at 1 until the synchronizer has flushed after reset, so a
  // button held through reset reads as already pressed and needs a release.
  // ------------------------------------------------------------------
  logic [4:0] btn_raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] prev;
  logic [1:0] flush;
  logic [4:0] pulse;

  assign btn_raw = {btn_ok, btn_right, btn_left, btn_down, btn_up};
  assign pulse   = sync2 & ~prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '1;
      flush <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      flush <= {flush[0], 1'b1};
      prev  <= flush[1] ? sync2 : '1;
    end
  end

  // ------------------------------------------------------------------
  // Per-axis step helpers
  // ------------------------------------------------------------------
  function automatic logic [2:0] step_inc(input logic [2:0] v);
`ifdef CHECKER_CURSOR_WRAP_EN
    return v + 3'd1;
`else
    return (v == 3'd7) ? v : v + 3'd1;
`endif
  endfunction

  function automatic logic [2:0] step_dec(input logic [2:0] v);
`ifdef CHECKER_CURSOR_WRAP_EN
    return v - 3'd1;
`else
    return (v == 3'd0) ? v : v - 3'd1;
`endif
  endfunction

  // ------------------------------------------------------------------
  // Turn FSM
  // ------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       cursor_nxt;
  logic [5:0]       select_nxt;
  logic [7:0]       latched, latched_nxt;
  logic             done_nxt;
  logic             timeout_nxt;
  logic             move_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_PICK;
      cnt          <= '0;
      cursor_loc   <= '0;
      select_loc   <= '0;
      latched      <= '0;
      move_done    <= 1'b0;
      move_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cursor_loc   <= cursor_nxt;
      select_loc   <= select_nxt;
      latched      <= latched_nxt;
      move_done    <= done_nxt;
      move_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cursor_nxt  = cursor_loc;
    select_nxt  = select_loc;
    latched_nxt = latched;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    move_en     = 1'b0;

    case (state)
      ST_PICK: begin
        if (pulse[B_OK]) begin
          select_nxt = cursor_loc;
          cnt_nxt    = '0;
          state_nxt  = ST_SETTLE;
        end else begin
          move_en = 1'b1;
        end
      end

      ST_SETTLE: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_DEST;
        end
      end

      ST_DEST: begin
        if (pulse[B_OK]) begin
          // select_loc still holds the picked square here, so confirming the
          // same square again is a cancel and the engine sees no new location.
          if (cursor_loc == select_loc) begin
            state_nxt = ST_PICK;
          end else begin
            select_nxt  = cursor_loc;
            latched_nxt = turn_count;
            cnt_nxt     = '0;
            state_nxt   = ST_WAIT;
          end
        end else begin
          move_en = 1'b1;
        end
      end

      ST_WAIT: begin
        // Count change is tested first so it wins over a simultaneous expiry.
        if (turn_count != latched) begin
          done_nxt  = 1'b1;
          state_nxt = ST_PICK;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_PICK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_PICK;
      end
    endcase

    // One axis per cycle, priority up > down > left > right.
    if (move_en) begin
      if (pulse[B_UP]) begin
        cursor_nxt[2:0] = step_inc(cursor_loc[2:0]);
      end else if (pulse[B_DOWN]) begin
        cursor_nxt[2:0] = step_dec(cursor_loc[2:0]);
      end else if (pulse[B_LEFT]) begin
        cursor_nxt[5:3] = step_dec(cursor_loc[5:3]);
      end else if (pulse[B_RIGHT]) begin
        cursor_nxt[5:3] = step_inc(cursor_loc[5:3]);
      end
    end
  end

  assign phase    = (state == ST_DEST) || (state == ST_WAIT);
  assign busy     = (state == ST_SETTLE) || (state == ST_WAIT);
  assign red_turn = ~turn_count[0];

endmodule

// File: tb/tb_checker_turn_ctrl.sv
// Bench for checker_turn_ctrl: vector table for cursor motion, hand sequences
// for settle/timeout/reset corners, then random presses against a press-level model.

`timescale 1ns/1ps

module tb_checker_turn_ctrl;

`ifdef CHECKER_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [4:0] M_U  = 5'b00001;
  localparam logic [4:0] M_D  = 5'b00010;
  localparam logic [4:0] M_L  = 5'b00100;
  localparam logic [4:0] M_R  = 5'b01000;
  localparam logic [4:0] M_OK = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_ok = 1'b0;
  logic [7:0] turn_count = 8'd0;
  logic [5:0] cursor_loc, select_loc;
  logic       phase, busy, move_done, move_timeout, red_turn;

  checker_turn_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_ok(btn_ok),
    .turn_count(turn_count),
    .cursor_loc(cursor_loc), .select_loc(select_loc),
    .phase(phase), .busy(busy),
    .move_done(move_done), .move_timeout(move_timeout),
    .red_turn(red_turn)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0, n_to = 0, t_done = -1, t_to = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (move_done) begin n_done <= n_done + 1; t_done <= cyc; end
    if (move_timeout) begin n_to <= n_to + 1; t_to <= cyc; end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0o%0o) expected %0d (0o%0o) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic drive(input logic [4:0] b);
    btn_up = b[0]; btn_down = b[1]; btn_left = b[2]; btn_right = b[3]; btn_ok = b[4];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise buttons, hold across the three edges the conditioner needs, release.
  task automatic press_hold(input logic [4:0] b);
    drive(b);
    idle(3);
    drive(5'b0);
  endtask

  task automatic press(input logic [4:0] b);
    press_hold(b);
    idle(3);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(5'b0);
    idle(2);
    rst = 1'b1;
    idle(3);
  endtask

  typedef struct {
    logic [4:0] b;
    logic [5:0] sat;
    logic [5:0] wrp;
  } vec_t;

  vec_t vec[15];

  // Reference model state (press level, integer coordinates)
  int mx, my, msel, mpick, mode;

  function automatic int step(input int v, input int d);
    int r;
    r = v + d;
    if (WRAP) return (r + 8) % 8;
    if (r < 0) return 0;
    if (r > 7) return 7;
    return r;
  endfunction

  task automatic model_move(input logic [4:0] b);
    if (b[0])      my = step(my, 1);
    else if (b[1]) my = step(my, -1);
    else if (b[2]) mx = step(mx, -1);
    else if (b[3]) mx = step(mx, 1);
  endtask

  initial begin
    int d0, t0, e, k;
    logic [4:0] b;

    vec[0]  = '{b: M_R,       sat: 6'o10, wrp: 6'o10};
    vec[1]  = '{b: M_R,       sat: 6'o20, wrp: 6'o20};
    vec[2]  = '{b: M_R,       sat: 6'o30, wrp: 6'o30};
    vec[3]  = '{b: M_U,       sat: 6'o31, wrp: 6'o31};
    vec[4]  = '{b: M_U,       sat: 6'o32, wrp: 6'o32};
    vec[5]  = '{b: M_D,       sat: 6'o31, wrp: 6'o31};
    vec[6]  = '{b: M_L,       sat: 6'o21, wrp: 6'o21};
    vec[7]  = '{b: M_U | M_R, sat: 6'o22, wrp: 6'o22};
    vec[8]  = '{b: M_D | M_L, sat: 6'o21, wrp: 6'o21};
    vec[9]  = '{b: M_L | M_R, sat: 6'o11, wrp: 6'o11};
    vec[10] = '{b: M_L,       sat: 6'o01, wrp: 6'o01};
    vec[11] = '{b: M_L,       sat: 6'o01, wrp: 6'o71};
    vec[12] = '{b: M_D,       sat: 6'o00, wrp: 6'o70};
    vec[13] = '{b: M_D,       sat: 6'o00, wrp: 6'o77};
    vec[14] = '{b: M_U,       sat: 6'o01, wrp: 6'o70};

    // ---- reset state ----
    idle(1);
    chk("rst_cursor", cursor_loc, 0);
    chk("rst_select", select_loc, 0);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", move_done, 0);
    chk("rst_timeout", move_timeout, 0);
    idle(1);
    rst = 1'b1;
    idle(3);

    // ---- vector table: cursor motion, priority, edges ----
    for (int i = 0; i < 15; i++) begin
      press(vec[i].b);
      chk($sformatf("tbl%0d_cursor", i), cursor_loc, WRAP ? vec[i].wrp : vec[i].sat);
      chk($sformatf("tbl%0d_select", i), select_loc, 0);
      chk($sformatf("tbl%0d_phase", i), phase, 0);
    end

    // ---- conditioner latency and held button ----
    do_reset();
    drive(M_R);
    idle(2);
    chk("lat_e2_cursor", cursor_loc, 6'o00);
    idle(1);
    chk("lat_e3_cursor", cursor_loc, 6'o10);
    idle(10);
    chk("held_once", cursor_loc, 6'o10);
    drive(5'b0);
    idle(3);
    press(M_U);
    chk("tp2_cursor", cursor_loc, 6'o11);

    // ---- pick, settle window, discarded pulse during settle ----
    drive(M_OK);
    idle(1);
    drive(M_OK | M_R);
    idle(2);
    chk("settle0_select", select_loc, 6'o11);
    chk("settle0_busy", busy, 1);
    chk("settle0_phase", phase, 0);
    drive(5'b0);
    idle(1);
    chk("settle1_busy", busy, 1);
    idle(1);
    chk("dest_busy", busy, 0);
    chk("dest_phase", phase, 1);
    idle(3);
    chk("settle_drop_cursor", cursor_loc, 6'o11);

    // ---- destination confirm, count changes 3 cycles later ----
    press(M_R);
    press(M_U);
    chk("dest_cursor", cursor_loc, 6'o22);
    d0 = n_done; t0 = n_to;
    press_hold(M_OK);
    e = cyc;
    chk("wait_busy", busy, 1);
    chk("wait_select", select_loc, 6'o22);
    repeat (3) @(posedge clk);
    #1 turn_count = 8'd1;
    idle(4);
    chk("done_count", n_done - d0, 1);
    chk("done_time", t_done - e, 4);
    chk("done_no_to", n_to - t0, 0);
    chk("done_phase", phase, 0);
    chk("done_red", red_turn, 0);
    chk("done_select", select_loc, 6'o22);

    // ---- timeout with constant count ----
    press(M_OK);
    press(M_U);
    d0 = n_done; t0 = n_to;
    press_hold(M_OK);
    e = cyc;
    idle(20);
    chk("to_count", n_to - t0, 1);
    chk("to_time", t_to - e, 16);
    chk("to_no_done", n_done - d0, 0);
    chk("to_phase", phase, 0);

    // ---- change arrives on the expiry cycle: done wins ----
    press(M_OK);
    press(M_D);
    d0 = n_done; t0 = n_to;
    press_hold(M_OK);
    e = cyc;
    repeat (15) @(posedge clk);
    #1 turn_count = 8'd2;
    idle(5);
    chk("tie_done", n_done - d0, 1);
    chk("tie_time", t_done - e, 16);
    chk("tie_no_to", n_to - t0, 0);

    // ---- change one cycle after expiry: timeout, late change ignored ----
    press(M_OK);
    press(M_U);
    d0 = n_done; t0 = n_to;
    press_hold(M_OK);
    e = cyc;
    repeat (16) @(posedge clk);
    #1 turn_count = 8'd3;
    idle(5);
    chk("late_to", n_to - t0, 1);
    chk("late_to_time", t_to - e, 16);
    chk("late_no_done", n_done - d0, 0);

    // ---- cancel: ok on the picked square ----
    press(M_OK);
    d0 = n_done; t0 = n_to;
    press_hold(M_OK);
    chk("cancel_busy", busy, 0);
    chk("cancel_phase", phase, 0);
    idle(20);
    chk("cancel_pulses", (n_done - d0) + (n_to - t0), 0);
    chk("cancel_select", select_loc, 6'o23);

    // ---- board edge, mixed presses ----
    repeat (5) press(M_R);
    chk("x7_cursor", cursor_loc, 6'o73);
    press(M_R);
    chk("x7_right", cursor_loc, WRAP ? 6'o03 : 6'o73);
    press(M_U | M_R);
    chk("up_right", cursor_loc, WRAP ? 6'o04 : 6'o74);
    press_hold(M_OK | M_U);
    chk("ok_up_cursor", cursor_loc, WRAP ? 6'o04 : 6'o74);
    chk("ok_up_busy", busy, 1);
    chk("ok_up_select", select_loc, WRAP ? 6'o04 : 6'o74);
    idle(3);
    press(M_OK);
    chk("ok_up_cancel", phase, 0);

    // ---- reset mid-turn, ok held across release ----
    press(M_OK);
    press(M_D);
    press_hold(M_OK);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cursor", cursor_loc, 0);
    chk("arst_select", select_loc, 0);
    chk("arst_phase", phase, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", move_done, 0);
    chk("arst_to", move_timeout, 0);
    drive(M_OK);
    idle(2);
    rst = 1'b1;
    idle(10);
    chk("held_ok_busy", busy, 0);
    chk("held_ok_phase", phase, 0);
    drive(5'b0);
    idle(3);
    press_hold(M_OK);
    chk("repress_busy", busy, 1);
    idle(3);
    press(M_OK);
    chk("repress_cancel", phase, 0);

    // ---- randomized presses against the model ----
    do_reset();
    mx = 0; my = 0; msel = 0; mpick = 0; mode = 0;
    for (int op = 0; op < 150; op++) begin
      if ($urandom_range(0, 7) == 0) begin
        turn_count = turn_count + 8'd1;
        idle(1);
      end
      b = {($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15))};
      d0 = n_done; t0 = n_to;
      if (b[4] && mode == 0) begin
        press_hold(b);
        chk("r_pick_busy", busy, 1);
        idle(3);
        msel = mx * 8 + my; mpick = msel; mode = 1;
        chk("r_pulses", (n_done - d0) + (n_to - t0), 0);
      end else if (b[4] && (mx * 8 + my) == mpick) begin
        press(b);
        mode = 0;
        chk("r_pulses", (n_done - d0) + (n_to - t0), 0);
      end else if (b[4]) begin
        press_hold(b);
        e = cyc;
        msel = mx * 8 + my;
        k = $urandom_range(0, 24);
        repeat (k) @(posedge clk);
        #1 turn_count = turn_count + 8'd1;
        idle((20 - k > 3) ? 20 - k : 3);
        if (k <= 15) begin
          chk("r_done", n_done - d0, 1);
          chk("r_done_time", t_done - e, k + 1);
          chk("r_done_no_to", n_to - t0, 0);
        end else begin
          chk("r_to", n_to - t0, 1);
          chk("r_to_time", t_to - e, 16);
          chk("r_to_no_done", n_done - d0, 0);
        end
        mode = 0;
      end else begin
        press(b);
        model_move(b);
        chk("r_pulses", (n_done - d0) + (n_to - t0), 0);
      end
      chk("r_cursor", cursor_loc, mx * 8 + my);
      chk("r_select", select_loc, msel);
      chk("r_phase", phase, mode);
      chk("r_red", red_turn, (turn_count % 2 == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
